accel_axi_lite_slave: RTL

AXI4-Lite responder for the accelerometer peripheral: register file plus sample-capture logic, addressed by the AXI4-Lite master in the block design. Four read/write registers (CTRL, SCRATCH0..2) hold software configuration. Two read-only registers expose the latest accelerometer sample and capture status. A level interrupt goes to the PS.

---
 rtl/accel_axi_lite_slave.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/accel_axi_lite_slave.sv
// Accelerometer AXI4-Lite responder: CTRL/SCRATCH0..2 RW, SAMPLE/STATUS RO.
// Captures sensor samples, counts overruns and raises a level irq to the PS.
// Ports: ACLK/ARESETN (async active-low); S_AXI_* AXI4-Lite slave channels;
//   sample_data/sample_valid from the sensor front end; ctrl_out = CTRL;
//   irq = registered CTRL[0] & new-sample flag.
// Build option: define ACCEL_AXI_SLVERR_EN for SLVERR on RO/unmapped access.
module accel_axi_lite_slave #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    ACLK,
   input  logic                    ARESETN,
   input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]              S_AXI_AWPROT,
   input  logic                    S_AXI_AWVALID,
   output logic                    S_AXI_AWREADY,
   input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                    S_AXI_WVALID,
   output logic                    S_AXI_WREADY,
   output logic [1:0]              S_AXI_BRESP,
   output logic                    S_AXI_BVALID,
   input  logic                    S_AXI_BREADY,
   input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]              S_AXI_ARPROT,
   input  logic                    S_AXI_ARVALID,
   output logic                    S_AXI_ARREADY,
   output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]              S_AXI_RRESP,
   output logic                    S_AXI_RVALID,
   input  logic                    S_AXI_RREADY,
   input  logic [DATA_WIDTH-1:0]   sample_data,
   input  logic                    sample_valid,
   output logic [DATA_WIDTH-1:0]   ctrl_out,
   output logic                    irq
);

`ifdef ACCEL_AXI_SLVERR_EN
   localparam logic [1:0] ERR_RESP = 2'b10;
`else
   localparam logic [1:0] ERR_RESP = 2'b00;
`endif

   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   w_state_t w_state, w_next;
   r_state_t r_state, r_next;

   logic                  aw_rdy, ar_rdy;
   logic                  wr_fire, rd_fire;
   logic [2:0]            aw_idx, ar_idx;
   logic [1:0]            bresp_q, rresp_q;
   logic [DATA_WIDTH-1:0] rdata_q, rd_mux;
   logic [DATA_WIDTH-1:0] ctrl, scr0, scr1, scr2, sample;
   logic [DATA_WIDTH-1:0] status;
   logic                  flag, irq_q;
   logic [7:0]            ovr;
   logic                  rd_sample, ovr_clr;
   logic                  unused_ok;

   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                        S_AXI_AWADDR, S_AXI_ARADDR};

   assign aw_idx  = S_AXI_AWADDR[4:2];
   assign ar_idx  = S_AXI_ARADDR[4:2];
   assign wr_fire = aw_rdy & S_AXI_AWVALID & S_AXI_WVALID;
   assign rd_fire = ar_rdy & S_AXI_ARVALID;

   // Consuming read of SAMPLE; a same-cycle new sample keeps the flag set.
   assign rd_sample = rd_fire && (ar_idx == 3'd4);
   assign ovr_clr   = wr_fire && (aw_idx == 3'd0)
                    && S_AXI_WSTRB[0] && S_AXI_WDATA[1];

   assign status = {16'h0, ovr, 7'h0, flag};

   function automatic logic [DATA_WIDTH-1:0] merge(
      input logic [DATA_WIDTH-1:0]   old,
      input logic [DATA_WIDTH-1:0]   d,
      input logic [DATA_WIDTH/8-1:0] s
   );
      logic [DATA_WIDTH-1:0] m;
      m = old;
      for (int i = 0; i < DATA_WIDTH/8; i++)
         if (s[i]) m[i*8 +: 8] = d[i*8 +: 8];
      return m;
   endfunction

   always_comb begin
      w_next = w_state;
      unique case (w_state)
         W_IDLE:  if (wr_fire) w_next = W_RESP;
         W_RESP:  if (S_AXI_BREADY) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   always_comb begin
      r_next = r_state;
      unique case (r_state)
         R_IDLE:  if (rd_fire) r_next = R_DATA;
         R_DATA:  if (S_AXI_RREADY) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   always_comb begin
      rd_mux = '0;
      unique case (ar_idx)
         3'd0:    rd_mux = ctrl;
         3'd1:    rd_mux = scr0;
         3'd2:    rd_mux = scr1;
         3'd3:    rd_mux = scr2;
         3'd4:    rd_mux = sample;
         3'd5:    rd_mux = status;
         default: rd_mux = '0;
      endcase
   end

   // Readies are registered so they are clean zeros under reset; each is a
   // one-cycle pulse raised once the master presents a complete request.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         w_state <= W_IDLE;
         r_state <= R_IDLE;
         aw_rdy  <= 1'b0;
         ar_rdy  <= 1'b0;
         bresp_q <= 2'b00;
         rresp_q <= 2'b00;
         rdata_q <= '0;
      end else begin
         w_state <= w_next;
         r_state <= r_next;
         aw_rdy  <= (w_state == W_IDLE) && S_AXI_AWVALID
                 && S_AXI_WVALID && !aw_rdy;
         ar_rdy  <= (r_state == R_IDLE) && S_AXI_ARVALID && !ar_rdy;
         if (wr_fire)
            bresp_q <= (aw_idx >= 3'd4) ? ERR_RESP : 2'b00;
         if (rd_fire) begin
            rdata_q <= rd_mux;
            rresp_q <= (ar_idx >= 3'd6) ? ERR_RESP : 2'b00;
         end
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         ctrl <= '0;
         scr0 <= '0;
         scr1 <= '0;
         scr2 <= '0;
      end else if (wr_fire) begin
         unique case (aw_idx)
            3'd0: ctrl <= merge(ctrl, S_AXI_WDATA, S_AXI_WSTRB)
                        & ~DATA_WIDTH'(2);
            3'd1: scr0 <= merge(scr0, S_AXI_WDATA, S_AXI_WSTRB);
            3'd2: scr1 <= merge(scr1, S_AXI_WDATA, S_AXI_WSTRB);
            3'd3: scr2 <= merge(scr2, S_AXI_WDATA, S_AXI_WSTRB);
            default: ;
         endcase
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         sample <= '0;
         flag   <= 1'b0;
         ovr    <= 8'h00;
         irq_q  <= 1'b0;
      end else begin
         irq_q <= ctrl[0] & flag;
         if (sample_valid) begin
            sample <= sample_data;
            flag   <= 1'b1;
         end else if (rd_sample) begin
            flag   <= 1'b0;
         end
         if (ovr_clr)
            ovr <= 8'h00;
         else if (sample_valid && flag && !rd_sample && ovr != 8'hFF)
            ovr <= ovr + 8'd1;
      end
   end

   assign S_AXI_AWREADY = aw_rdy;
   assign S_AXI_WREADY  = aw_rdy;
   assign S_AXI_BVALID  = (w_state == W_RESP);
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_ARREADY = ar_rdy;
   assign S_AXI_RVALID  = (r_state == R_DATA);
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = rresp_q;
   assign ctrl_out      = ctrl;
   assign irq           = irq_q;

endmodule
